// File: rtl/extension_inmediato_if.sv
// Immediate-extender bus: ID-stage operands in, extended operand out.
// offsetRama exists only when EXT_BRANCH_OFFSET_EN is defined.
interface extension_inmediato_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic [IN_W-1:0]  valEntrada;
    logic [1:0]       modo;
    logic             val_in;
    logic             stall;
    logic             flush;
    logic [OUT_W-1:0] valExtendido;
    logic             val_out;
    logic             err_modo;
`ifdef EXT_BRANCH_OFFSET_EN
    logic [OUT_W-1:0] offsetRama;

    modport master (
        output valEntrada, modo, val_in, stall, flush,
        input  valExtendido, val_out, err_modo, offsetRama
    );
    modport slave (
        input  valEntrada, modo, val_in, stall, flush,
        output valExtendido, val_out, err_modo, offsetRama
    );
`else
    modport master (
        output valEntrada, modo, val_in, stall, flush,
        input  valExtendido, val_out, err_modo
    );
    modport slave (
        input  valEntrada, modo, val_in, stall, flush,
        output valExtendido, val_out, err_modo
    );
`endif
endinterface

// File: rtl/extension_inmediato.sv
// Pipelined immediate extender (sign/zero/upper) with stall and flush.
// Optional branch offset output enabled by EXT_BRANCH_OFFSET_EN.
module extension_inmediato #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int STAGES = 1
) (
    input logic                  clk,
    input logic                  reset,
    extension_inmediato_if.slave bus
);
    localparam int PAD = OUT_W - IN_W;

    logic [OUT_W-1:0]  w_ext;
    logic              w_err;
    logic [OUT_W-1:0]  r_res [STAGES];
    logic [STAGES-1:0] r_err;
    logic [STAGES-1:0] r_vld;

    always_comb begin
        w_ext = '0;
        w_err = 1'b0;
        unique case (bus.modo)
            2'd0:    w_ext = OUT_W'($signed(bus.valEntrada));
            2'd1:    w_ext = OUT_W'(bus.valEntrada);
            2'd2:    w_ext = OUT_W'(bus.valEntrada) << PAD;
            default: w_err = 1'b1;
        endcase
    end

    // Flush only kills valid/err; data is left alone since nothing reads it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_res[k] <= '0;
            end
            r_err <= '0;
            r_vld <= '0;
        end else if (bus.flush) begin
            r_err <= '0;
            r_vld <= '0;
        end else if (!bus.stall) begin
            r_res[0] <= w_ext;
            r_err[0] <= w_err;
            r_vld[0] <= bus.val_in;
            for (int k = 1; k < STAGES; k++) begin
                r_res[k] <= r_res[k-1];
                r_err[k] <= r_err[k-1];
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    assign bus.valExtendido = r_res[STAGES-1];
    assign bus.val_out      = r_vld[STAGES-1];
    assign bus.err_modo     = r_err[STAGES-1] & r_vld[STAGES-1];

`ifdef EXT_BRANCH_OFFSET_EN
    assign bus.offsetRama = {r_res[STAGES-1][OUT_W-3:0], 2'b00};
`endif
endmodule

// File: tb/tb_extension_inmediato.sv
// Bench for extension_inmediato: STAGES=1 and STAGES=3 copies share stimulus.
// Expected results flow through per-DUT scoreboard queues.
module tb_extension_inmediato;
    typedef struct {
        logic [15:0] v;
        logic [1:0]  m;
        logic        vin;
        logic [31:0] res;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] valEntrada = '0;
    logic [1:0]  modo = '0;
    logic        val_in = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    int checks = 0;
    int failures = 0;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1v;
    exp_t e3v;
    logic sk1;
    logic sk3;

    always #5 clk = ~clk;

    extension_inmediato_if #(.IN_W(16), .OUT_W(32)) if1 ();
    extension_inmediato_if #(.IN_W(16), .OUT_W(32)) if3 ();

    assign if1.valEntrada = valEntrada;
    assign if1.modo       = modo;
    assign if1.val_in     = val_in;
    assign if1.stall      = stall;
    assign if1.flush      = flush;
    assign if3.valEntrada = valEntrada;
    assign if3.modo       = modo;
    assign if3.val_in     = val_in;
    assign if3.stall      = stall;
    assign if3.flush      = flush;

    extension_inmediato #(.IN_W(16), .OUT_W(32), .STAGES(1)) u1 (
        .clk(clk), .reset(reset), .bus(if1)
    );
    extension_inmediato #(.IN_W(16), .OUT_W(32), .STAGES(3)) u3 (
        .clk(clk), .reset(reset), .bus(if3)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] v, input logic [1:0] m,
                         input logic vin, input logic st, input logic fl,
                         input logic [31:0] res, input logic err);
        exp_t e;
        @(negedge clk);
        valEntrada = v;
        modo       = m;
        val_in     = vin;
        stall      = st;
        flush      = fl;
        if (vin && !st && !fl && !reset) begin
            e.res = res;
            e.err = err;
            q1.push_back(e);
            q3.push_back(e);
        end
    endtask

    task automatic idle();
        drive(16'h0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // A new result is produced only on edges that were not held or cleared.
    always begin
        @(posedge clk);
        sk1 = stall | flush | reset;
        #1;
        if (!sk1 && if1.val_out) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d1_unexpected got=%h want=none", if1.valExtendido);
            end else begin
                e1v = q1.pop_front();
                chk("d1_res", if1.valExtendido, e1v.res);
                chk("d1_err", 32'(if1.err_modo), 32'(e1v.err));
`ifdef EXT_BRANCH_OFFSET_EN
                chk("d1_off", if1.offsetRama, {e1v.res[29:0], 2'b00});
`endif
            end
        end
    end

    always begin
        @(posedge clk);
        sk3 = stall | flush | reset;
        #1;
        if (!sk3 && if3.val_out) begin
            if (q3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d3_unexpected got=%h want=none", if3.valExtendido);
            end else begin
                e3v = q3.pop_front();
                chk("d3_res", if3.valExtendido, e3v.res);
                chk("d3_err", 32'(if3.err_modo), 32'(e3v.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[10];
        vt[0] = '{16'h8000, 2'd0, 1'b1, 32'hFFFF8000, 1'b0};
        vt[1] = '{16'h7FFF, 2'd0, 1'b1, 32'h00007FFF, 1'b0};
        vt[2] = '{16'h8000, 2'd1, 1'b1, 32'h00008000, 1'b0};
        vt[3] = '{16'h1234, 2'd2, 1'b1, 32'h12340000, 1'b0};
        vt[4] = '{16'hFFFC, 2'd0, 1'b1, 32'hFFFFFFFC, 1'b0};
        vt[5] = '{16'hABCD, 2'd3, 1'b1, 32'h00000000, 1'b1};
        vt[6] = '{16'h0001, 2'd2, 1'b1, 32'h00010000, 1'b0};
        vt[7] = '{16'hFFFF, 2'd1, 1'b1, 32'h0000FFFF, 1'b0};
        vt[8] = '{16'h5555, 2'd0, 1'b0, 32'h00000000, 1'b0};
        vt[9] = '{16'h8001, 2'd2, 1'b1, 32'h80010000, 1'b0};

        repeat (2) tick();
        chk("rst_d1_val", 32'(if1.val_out), 32'h0);
        chk("rst_d1_res", if1.valExtendido, 32'h0);
        chk("rst_d1_err", 32'(if1.err_modo), 32'h0);
        chk("rst_d3_val", 32'(if3.val_out), 32'h0);
        chk("rst_d3_res", if3.valExtendido, 32'h0);
        chk("rst_d3_err", 32'(if3.err_modo), 32'h0);
`ifdef EXT_BRANCH_OFFSET_EN
        chk("rst_d1_off", if1.offsetRama, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back table stream
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].v, vt[i].m, vt[i].vin, 1'b0, 1'b0, vt[i].res, vt[i].err);
        end
        repeat (5) idle();
        chk("tbl_q1_drained", 32'(q1.size()), 32'h0);
        chk("tbl_q3_drained", 32'(q3.size()), 32'h0);

        // Illegal mode with no instruction must not raise err_modo
        drive(16'hABCD, 2'd3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        chk("ill_novld_d1_val", 32'(if1.val_out), 32'h0);
        chk("ill_novld_d1_err", 32'(if1.err_modo), 32'h0);
        idle(); tick();
        idle(); tick();
        chk("ill_novld_d3_val", 32'(if3.val_out), 32'h0);
        chk("ill_novld_d3_err", 32'(if3.err_modo), 32'h0);
        idle(); tick();

        // Stall for two edges after the second input
        drive(16'h0001, 2'd1, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0); tick();
        drive(16'h0002, 2'd1, 1'b1, 1'b0, 1'b0, 32'h2, 1'b0); tick();
        chk("st_d3_pre", 32'(if3.val_out), 32'h0);
        drive(16'h0099, 2'd1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0); tick();
        chk("st1_d3_val", 32'(if3.val_out), 32'h0);
        chk("st1_d1_hold", if1.valExtendido, 32'h2);
        drive(16'h0099, 2'd1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0); tick();
        chk("st2_d3_val", 32'(if3.val_out), 32'h0);
        chk("st2_d1_val", 32'(if1.val_out), 32'h1);
        drive(16'h0003, 2'd1, 1'b1, 1'b0, 1'b0, 32'h3, 1'b0); tick();
        chk("st_out1_val", 32'(if3.val_out), 32'h1);
        chk("st_out1_res", if3.valExtendido, 32'h1);
        idle(); tick();
        chk("st_out2_res", if3.valExtendido, 32'h2);
        idle(); tick();
        chk("st_out3_res", if3.valExtendido, 32'h3);
        idle(); tick();
        chk("st_after_val", 32'(if3.val_out), 32'h0);

        // Flush and stall together with a value in flight
        drive(16'h0010, 2'd1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0); tick();
        drive(16'h0020, 2'd1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0); tick();
        chk("fl_d1_val", 32'(if1.val_out), 32'h0);
        chk("fl_d3_val", 32'(if3.val_out), 32'h0);
        q1.delete();
        q3.delete();
        drive(16'h0030, 2'd1, 1'b1, 1'b0, 1'b0, 32'h30, 1'b0); tick();
        chk("fl_d1_next", if1.valExtendido, 32'h30);
        chk("fl_d3_wait1", 32'(if3.val_out), 32'h0);
        idle(); tick();
        chk("fl_d3_wait2", 32'(if3.val_out), 32'h0);
        idle(); tick();
        chk("fl_d3_next_val", 32'(if3.val_out), 32'h1);
        chk("fl_d3_next_res", if3.valExtendido, 32'h30);
        idle(); tick();

        // Reset mid-stream
        drive(16'h0040, 2'd0, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0); tick();
        drive(16'hF050, 2'd0, 1'b1, 1'b0, 1'b0, 32'hFFFFF050, 1'b0); tick();
        @(negedge clk);
        reset  = 1'b1;
        val_in = 1'b0;
        tick();
        chk("mrst_d1_val", 32'(if1.val_out), 32'h0);
        chk("mrst_d1_res", if1.valExtendido, 32'h0);
        chk("mrst_d3_val", 32'(if3.val_out), 32'h0);
        chk("mrst_d3_res", if3.valExtendido, 32'h0);
        chk("mrst_d3_err", 32'(if3.err_modo), 32'h0);
        q1.delete();
        q3.delete();
        @(negedge clk);
        reset = 1'b0;
        drive(16'h8001, 2'd0, 1'b1, 1'b0, 1'b0, 32'hFFFF8001, 1'b0); tick();
        chk("mrst_resume", if1.valExtendido, 32'hFFFF8001);
        repeat (4) idle();
        tick();
        chk("end_q1_drained", 32'(q1.size()), 32'h0);
        chk("end_q3_drained", 32'(q3.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/extension_inmediato.md
# extension_inmediato

- Parametrised, pipelined immediate extender for the ID stage of the MIPS pipeline.
- Takes an IN_W-bit instruction immediate and produces an OUT_W-bit operand. Modes: sign-extend, zero-extend, or upper placement for LUI.
- Carries a valid bit through STAGES register stages, with stall and flush control that match the pipeline hazard unit.
- Optionally produces the branch offset (extended value shifted left by 2).

## Interface
Parameters:
- IN_W, 16, immediate width; 2 ≤ IN_W ≤ OUT_W.
- OUT_W, 32, extended operand width.
- STAGES, 1, register stages from input to output; legal values 1..3.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- valEntrada  input  IN_W  immediate field.
- modo  input  2  0 = sign-extend, 1 = zero-extend, 2 = upper, 3 = illegal.
- val_in  input  1  input is a real instruction.
- stall  input  1  hold every stage.
- flush  input  1  invalidate every stage.
- valExtendido  output  OUT_W  extended result.
- val_out  output  1  valExtendido is meaningful.
- err_modo  output  1  result came from modo = 3.
- offsetRama  output  OUT_W  valExtendido << 2. Present only with EXT_BRANCH_OFFSET_EN.

## Operation
- Extension function, combinational at stage-0 input:
  - mode 0: upper OUT_W−IN_W bits copy valEntrada[IN_W−1].
  - mode 1: upper bits are 0.
  - mode 2: valEntrada << (OUT_W−IN_W), low bits 0. When IN_W = OUT_W this equals mode 1.
  - mode 3: result 0, err bit 1.
- Each stage register holds {result, err, valid}. Stage 0 captures the function output and val_in; stage k captures stage k−1. Outputs come directly from the last stage.
- Per-edge priority, highest first:
  - reset: all stage registers cleared (result 0, err 0, valid 0).
  - flush: all valid bits cleared, all err bits cleared, data may hold or change.
  - stall: all stages hold, input ignored.
  - otherwise: shift.
- flush together with stall: flush wins and valid clears.
- Illegal mode with val_in = 0: err is still captured but must be ignored. err_modo = err bit AND valid bit, so it is only asserted with val_out.
- Reset values: valExtendido = 0, val_out = 0, err_modo = 0, offsetRama = 0.

## Timing
- Latency is exactly STAGES cycles from input sampled with stall = 0 to the output, plus one cycle per stall edge in between.
- Throughput is one input per non-stalled cycle; no bubbles are inserted.
- Stall asserted for N edges freezes all outputs for those N edges. The value in flight emerges unchanged afterward.
- Flush on edge t: val_out = 0 from t+1. An input presented at edge t is discarded. The input at t+1 appears at t+1+STAGES.
- Reset mid-stream: identical to power-up. Nothing in flight survives.
- No combinational path from any input to any output.

## Configuration
- EXT_BRANCH_OFFSET_EN defined:
  - offsetRama port exists, equal to {valExtendido[OUT_W−3:0], 2'b00}, taken from the same last-stage register (no extra latency).
  - reset value 0.
- Not defined: port and logic are absent. All other behaviour is identical.

## Test plan
Defaults used: IN_W = 16, OUT_W = 32, STAGES = 1, unless noted.
- Sign: valEntrada = 0x8000, modo = 0, val_in = 1 → next edge valExtendido = 0xFFFF8000, val_out = 1. Input 0x7FFF → 0x00007FFF.
- Zero and upper modes:
  - 0x8000 with modo = 1 → 0x00008000.
  - 0x1234 with modo = 2 → 0x12340000.
  - With macro on, 0xFFFC with modo = 0 → offsetRama = 0xFFFFFFF0.
- Illegal: modo = 3, val_in = 1 → valExtendido = 0, err_modo = 1, val_out = 1. With val_in = 0 → err_modo = 0.
- STAGES = 3, stream 1, 2, 3 with stall held over 2 edges after the second input → outputs 1, 2, 3 in order, each 3 + 2 edges after capture where the stall applied. No duplicates or drops.
- Flush + stall on the same edge with a valid value in flight → val_out = 0 next cycle. The next input appears STAGES cycles later.
- Reset asserted mid-stream for one edge → all outputs 0 the following cycle. Normal extension resumes on the next input.
